// File: rtl/divider_unit_if.sv
// Operand/result bundle between the execute stage (master) and the divider (slave).
interface divider_unit_if;
    logic        stall;
    logic        start;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [1:0]  ctrl;
    logic        busy;
    logic        done;
    logic [31:0] ans;

    modport master (
        output stall, start, rs1_value, rs2_value, ctrl,
        input  busy, done, ans
    );

    modport slave (
        input  stall, start, rs1_value, rs2_value, ctrl,
        output busy, done, ans
    );
endinterface

// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides magnitudes over 32 cycles, then fixes signs and holds the result until released.
module divider_unit (
    input  logic          clk,
    input  logic          resetn,
    divider_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic [31:0] ans_r;
    logic [4:0]  count;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        overflow;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_final;
    logic [31:0] r_final;

    always_comb begin
        signed_op = ~bus.ctrl[0];
        a_neg     = signed_op & bus.rs1_value[31];
        b_neg     = signed_op & bus.rs2_value[31];
        a_mag     = a_neg ? -bus.rs1_value : bus.rs1_value;
        b_mag     = b_neg ? -bus.rs2_value : bus.rs2_value;
        div_zero  = (bus.rs2_value == 32'd0);
        overflow  = signed_op && (bus.rs1_value == 32'h8000_0000) && (bus.rs2_value == 32'hFFFF_FFFF);
    end

    // The partial remainder is always below the divisor, so a 33-bit difference
    // never wraps and its top bit is a reliable sign.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, divisor};
        q_final = neg_q ? -quo : quo;
        r_final = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            ans_r <= 32'd0;
            count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_rem  <= bus.ctrl[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        rem     <= 32'd0;
                        count   <= 5'd0;
                        if (div_zero) begin
                            ans_r <= bus.ctrl[1] ? bus.rs1_value : 32'hFFFF_FFFF;
                            state <= DONE;
                        end else if (overflow) begin
                            ans_r <= bus.ctrl[1] ? 32'd0 : 32'h8000_0000;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= diff[32] ? shifted[31:0] : diff[31:0];
                    quo   <= {quo[30:0], ~diff[32]};
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    ans_r <= is_rem ? r_final : q_final;
                    state <= DONE;
                end
                DONE: begin
                    if (!bus.stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = resetn & (((state == IDLE) & bus.start) | (state == RUN) | (state == FIX));
    assign bus.done = (state == DONE);
    assign bus.ans  = ans_r;
endmodule

// File: doc/divider_unit.md
# divider_unit

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage beside the two-stage multiplier and takes the same `rs1_value`/`rs2_value` operands from the register-read stage. Its 32-bit result goes to the same execute result mux. While a division is in flight it holds the pipeline through `busy`, and it returns a result that stays stable until the pipeline releases the instruction.

## Interface
No parameters; the datapath width is fixed at 32.

- `clk`  in  1  single clock; all state updates on the rising edge
- `resetn`  in  1  synchronous, active-low reset
- `stall`  in  1  external pipeline stall; only affects the DONE state
- `start`  in  1  a division instruction is present in execute; held high until the pipeline advances
- `rs1_value`  in  32  dividend
- `rs2_value`  in  32  divisor
- `ctrl`  in  2  `[0]` = unsigned (DIVU/REMU), `[1]` = remainder (REM/REMU); equal to funct3[1:0]
- `busy`  out  1  stall request to the pipeline
- `done`  out  1  `ans` is valid
- `ans`  out  32  quotient or remainder

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - When `start` is high, latch the operands and `ctrl`.
  - Divisor == 0: go to DONE. Quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed, dividend == 0x80000000 and divisor == 0xFFFFFFFF: go to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise go to RUN with iteration count = 0.
- **RUN**
  - Signed ops work on magnitudes |a| and |b|; unsigned ops use the operands as-is.
  - Each cycle: shift the 33-bit partial remainder left by one, inserting the next dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift a 1 into the quotient; otherwise restore and shift in a 0.
  - After 32 iterations go to FIX.
  - Iterations continue regardless of `stall` and `start`.
- **FIX**
  - Signed quotient is negated when sign(a) XOR sign(b) = 1.
  - Signed remainder is negated when sign(a) = 1, so the remainder takes the sign of the dividend.
  - Register the selected result into `ans`, then go to DONE.
- **DONE**
  - `done` = 1 and `ans` is held.
  - `start` is ignored here: it is still the same instruction.
  - If `stall` = 0, go to IDLE next cycle. If `stall` = 1, remain in DONE with `ans` unchanged.
- `busy` is combinational:
  - 1 when in IDLE with `start` = 1, or in RUN or FIX;
  - 0 in DONE, and in IDLE with `start` = 0;
  - forced to 0 while `resetn` = 0.
- A `start` arriving in RUN or FIX is ignored. The pipeline cannot present one there, because `busy` is high.
- Reset: when `resetn` = 0 at a clock edge, state goes to IDLE and `ans` = 0, `done` = 0. This applies mid-operation; a partial result is discarded.

## Timing
- Start edge = first rising edge with state IDLE and `start` = 1 (call it cycle 0).
- Normal path:
  - RUN occupies cycles 1–32 and FIX cycle 33.
  - `done` is high from cycle 34.
  - `busy` is high from cycle 0 (combinationally) through cycle 33.
- Fast path (divide by zero, signed overflow): `done` is high in cycle 1; `busy` is high only in cycle 0.
- `ans` changes only on entry to DONE or on reset. It is never stable-but-invalid while `done` = 1.
- Back-to-back divisions: DONE with `stall` = 0 → IDLE. The next `start` is accepted on the edge after that, so there is one idle cycle between results.
- Reset values: `ans` = 0, `done` = 0, `busy` = 0.

## Test plan
- DIVU 100 / 7, `stall` = 0
  - `busy` high in cycles 0–33;
  - `done` in cycle 34 with `ans` = 14;
  - the REMU repeat gives `ans` = 2.
- Signed operands
  - REM 0xFFFFFFF9 (−7) / 2 → `ans` = 0xFFFFFFFF (−1).
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - DIV 7 / −2 → 0xFFFFFFFD.
- Divide by zero
  - DIV 0x12345678 / 0 → `done` in cycle 1, `ans` = 0xFFFFFFFF.
  - REMU 0x12345678 / 0 → `ans` = 0x12345678.
- Signed overflow
  - DIV 0x80000000 / 0xFFFFFFFF → `ans` = 0x80000000 in cycle 1.
  - REM with the same operands → 0.
  - DIVU with the same operands → normal path, `ans` = 0 at cycle 34.
- Stall hold and back-to-back
  - Hold `stall` = 1 for 5 cycles after `done` rises: `done` and `ans` stay stable and `start` (still high) does not restart.
  - Release `stall`, then present DIVU 0xFFFFFFFF / 1: `ans` = 0xFFFFFFFF, 34 cycles after its start edge.
- Reset mid-RUN
  - Drive `resetn` = 0 at cycle 10 of a division: next cycle shows IDLE, `ans` = 0, `done` = 0, `busy` = 0.
  - A subsequent DIVU 9 / 3 completes correctly with `ans` = 3.
